// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: one word transaction on a req/ack bus with timeout and alignment checks
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] alu_result,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] wb_data,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic [8:0] cnt_inc;
  logic       mem_op;

  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign mem_op  = mem_read | mem_write;

  assign busy    = (state != IDLE);
  assign bus_req = (state == REQ);
  assign done    = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      err       <= 1'b0;
      wb_data   <= 16'h0000;
      bus_we    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if ((mem_read && mem_write) || (mem_op && alu_result[0])) begin
              err     <= 1'b1;
              wb_data <= alu_result;
              state   <= RESP;
            end else if (mem_op) begin
              bus_addr  <= alu_result;
              bus_we    <= mem_write;
              bus_wdata <= wr_data;
              cnt       <= 8'd0;
              err       <= 1'b0;
              state     <= REQ;
            end else begin
              wb_data <= alu_result;
              err     <= 1'b0;
              state   <= RESP;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            // a completed store reports its address as the write-back value
            wb_data <= bus_we ? bus_addr : bus_rdata;
            state   <= RESP;
          end else begin
            if (cnt != 8'hFF) cnt <= cnt_inc[7:0];
            if (cnt_inc >= TIMEOUT_W) begin
              err     <= 1'b1;
              wb_data <= 16'h0000;
              state   <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute ALU. It takes the 16-bit ALU result as a byte address (loads/stores) or as a pass-through value (all other ops) and runs a single word transaction on a request/acknowledge data-memory bus, with timeout and alignment checks. It stalls the processor through `busy` until the access completes and presents a registered write-back value.

## Interface
Parameters:
- `TIMEOUT`, 15: number of cycles `bus_req` may wait for `bus_ack` before the access is aborted. Legal range is 1..255.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that qualifies the inputs below. Ignored while `busy`=1.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `alu_result` in 16: address, or the pass-through value, from execute.
- `wr_data` in 16: store data.
- `busy` out 1: stall request to fetch/decode.
- `done` out 1: one-cycle completion pulse.
- `wb_data` out 16: registered write-back value.
- `err` out 1: access fault for the last access.
- `bus_req` out 1: memory request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 16: memory address.
- `bus_wdata` out 16: memory write data.
- `bus_ack` in 1: memory acknowledge.
- `bus_rdata` in 16: read data. Valid only when `bus_ack`=1.

## Operation
- There are three states: IDLE, REQ, RESP. Reset value is IDLE.
- In IDLE, `start`=1 is decoded as follows. This is priority order; the first match wins.
  1. `mem_read`=1 and `mem_write`=1: illegal. Latch `err`=1 and `wb_data`=`alu_result`, then go to RESP. No bus cycle.
  2. Either `mem_read` or `mem_write` is 1 and `alu_result[0]`=1: misaligned. Latch `err`=1 and `wb_data`=`alu_result`, then go to RESP. No bus cycle.
  3. Either `mem_read` or `mem_write` is 1 and the address is aligned:
     - Register `bus_addr`=`alu_result`, `bus_we`=`mem_write`, `bus_wdata`=`wr_data`.
     - Clear the timeout counter and `err`, then go to REQ.
  4. Neither `mem_read` nor `mem_write`: pass-through. Latch `wb_data`=`alu_result` and `err`=0, then go to RESP.
- In REQ:
  - `bus_req`=1. `bus_addr`, `bus_we` and `bus_wdata` stay stable.
  - `bus_ack`=1: go to RESP. A read latches `wb_data`=`bus_rdata`; a write latches `wb_data`=`bus_addr`.
  - `bus_ack`=0: increment the counter. At the edge where the counter would reach `TIMEOUT`, latch `err`=1, latch `wb_data`=16'h0000, and go to RESP.
- In RESP: `done`=1 for this single cycle, then go to IDLE.
- `bus_ack` is ignored outside REQ.
- `err` and `wb_data` hold their values until the next accepted `start`.
- The counter is 8 bits wide. It saturates and never wraps.

## Timing
- Outputs:
  - `busy` = (state != IDLE), combinational from state.
  - `bus_req` = (state == REQ).
  - `done` = (state == RESP).
- Reset values:
  - state IDLE, counter 0.
  - `busy`, `done`, `err`, `bus_req`, `bus_we` all 0.
  - `wb_data`, `bus_addr`, `bus_wdata` all 16'h0000.
- Latency, with `start` at edge-cycle N:
  - Pass-through or fault: `done` in cycle N+1.
  - Bus access with `bus_ack` in the first REQ cycle (N+1): `done` in N+2.
  - Each cycle of ack delay adds one cycle.
  - Timeout: REQ lasts exactly `TIMEOUT` cycles, then `done` follows in the next cycle.
- `start` arriving in REQ or RESP is dropped. The stage does not queue requests.
- If `start` arrives in the same cycle as RESP, it is still dropped. The next `start` is accepted in IDLE only.
- Reset mid-access: the next edge forces IDLE and `bus_req`=0. No `done` pulse is produced. An ack arriving in that same cycle is discarded.

## Test plan
- **Load, ack in first REQ cycle.** `start`, `mem_read`, `alu_result`=16'h0010, memory returns 16'hBEEF. Required:
  - `bus_req` high in N+1 only, with `bus_addr`=16'h0010 and `bus_we`=0.
  - `done` in N+2 with `wb_data`=16'hBEEF and `err`=0.
- **Store, ack delayed.** `mem_write`, addr 16'h0020, `wr_data`=16'h1234, ack after 3 wait cycles. Required:
  - `bus_req` high for 4 cycles, with `bus_we`=1 and `bus_wdata`=16'h1234 stable throughout.
  - `done` the cycle after the ack; `wb_data`=16'h0020.
- **Pass-through.** No mem op, `alu_result`=16'h7FFF. Required: `done` in N+1, `wb_data`=16'h7FFF, `bus_req` never asserted, `busy` high 1 cycle.
- **Faults.**
  - Misaligned load at 16'h0011: `done` in N+1 with `err`=1 and no bus cycle.
  - `mem_read`=`mem_write`=1: same response.
- **Timeout.** `TIMEOUT`=4, ack never arrives. Required: `bus_req` high exactly 4 cycles, then `done` with `err`=1 and `wb_data`=16'h0000.
- **Dropped start and reset mid-access.**
  - A second `start` during REQ is ignored: only one `done` is produced.
  - `rst` asserted during REQ: `bus_req` is 0 after the edge, all outputs take their reset values, and no `done` follows.
